// File: rtl/rtlola_diff_freq_monitor.sv
// RTLola runtime monitor: one signed input stream a, periodic streams b, c, d at
// PERIOD_B / PERIOD_C / PERIOD_D cycles, all phased off a single hyperperiod counter.
module rtlola_diff_freq_monitor #(
   parameter int unsigned CLK_FREQ_HZ = 32'd100_000_000,
   parameter int unsigned PERIOD_B    = 32'd10_000,
   parameter int unsigned PERIOD_C    = 32'd20_000,
   parameter int unsigned PERIOD_D    = 32'd40_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic signed [31:0] a,
   output logic               result_0,
   output logic signed [31:0] result_1,
   output logic signed [31:0] result_2,
   output logic signed [31:0] result_3,
   output logic signed [31:0] result_4
);

   localparam int unsigned CW = $clog2(PERIOD_D);
   localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
   localparam logic [CW-1:0] B_1ST   = CW'(PERIOD_B - 32'd1);
   localparam logic [CW-1:0] B_3RD   = CW'(32'd3 * PERIOD_B - 32'd1);
   localparam logic [CW-1:0] C_1ST   = CW'(PERIOD_C - 32'd1);
   localparam logic [CW-1:0] D_LAST  = CW'(PERIOD_D - 32'd1);

   generate
      if ((PERIOD_C != 32'd2 * PERIOD_B) || (PERIOD_D != 32'd2 * PERIOD_C) ||
          (PERIOD_B < 32'd2) || (CLK_FREQ_HZ == 32'd0)) begin : g_bad_params
         $error("rtlola_diff_freq_monitor: periods must satisfy D = 2C = 4B");
      end
   endgenerate

   logic [CW-1:0]      cnt;
   logic               tick_b;
   logic               tick_c;
   logic               tick_d;
   logic signed [31:0] c_next;
   logic signed [31:0] d_next;

   // Since PERIOD_D = 4*PERIOD_B, the modulo conditions reduce to fixed counter matches;
   // c and d see the freshly evaluated b (= a) within the same timestamp.
   always_comb begin
      tick_d = (cnt == D_LAST);
      tick_c = tick_d || (cnt == C_1ST);
      tick_b = tick_c || (cnt == B_1ST) || (cnt == B_3RD);
      c_next = result_3 + a;
      d_next = c_next + a;
   end

   // Hyperperiod counter and stream registers; result_3 doubles as c's offset(-1) history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= {CW{1'b0}};
         result_0 <= 1'b0;
         result_1 <= 32'sd0;
         result_2 <= 32'sd0;
         result_3 <= 32'sd0;
         result_4 <= 32'sd0;
      end else if (en) begin
         cnt      <= tick_d ? {CW{1'b0}} : cnt + CNT_ONE;
         result_0 <= tick_b;
         result_1 <= a;
         if (tick_b) result_2 <= a;
         else        result_2 <= result_2;
         if (tick_c) result_3 <= c_next;
         else        result_3 <= result_3;
         if (tick_d) result_4 <= d_next;
         else        result_4 <= result_4;
      end else begin
         cnt      <= cnt;
         result_0 <= 1'b0;
         result_1 <= result_1;
         result_2 <= result_2;
         result_3 <= result_3;
         result_4 <= result_4;
      end
   end

endmodule

// File: tb/tb_rtlola_diff_freq_monitor.sv
// Directed bench for rtlola_diff_freq_monitor with scaled-down periods; a reference
// model pushes expected stream values at each b tick and pops them on result_0.
module tb_rtlola_diff_freq_monitor;

   localparam int PB = 100;
   localparam int PC = 200;
   localparam int PD = 400;

   logic               clk;
   logic               rst;
   logic               en;
   logic signed [31:0] a;
   logic               result_0;
   logic signed [31:0] result_1, result_2, result_3, result_4;

   rtlola_diff_freq_monitor #(
      .CLK_FREQ_HZ(32'd100_000_000),
      .PERIOD_B   (PB),
      .PERIOD_C   (PC),
      .PERIOD_D   (PD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .a       (a),
      .result_0(result_0),
      .result_1(result_1),
      .result_2(result_2),
      .result_3(result_3),
      .result_4(result_4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          mcnt;
   logic [31:0] mb, mc, md, exp_r1;
   logic        exp_pulse;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mcnt = 0; mb = 32'd0; mc = 32'd0; md = 32'd0;
      exp_r1 = 32'd0; exp_pulse = 1'b0;
      sb.delete();
   endtask

   // One clock edge: advance the model with the current inputs, then check the DUT.
   task automatic cycle();
      logic tb_t, tc_t, td_t;
      logic [31:0] nb, nc, nd;
      exp_t e;
      if (!rst) begin
         model_reset();
      end else if (en) begin
         tb_t = ((mcnt + 1) % PB) == 0;
         tc_t = ((mcnt + 1) % PC) == 0;
         td_t = (mcnt == PD - 1);
         nb = tb_t ? a : mb;
         nc = tc_t ? mc + a : mc;
         nd = td_t ? nc + nb : md;
         if (tb_t) sb.push_back({nb, nc, nd});
         mb = nb; mc = nc; md = nd;
         mcnt = (mcnt == PD - 1) ? 0 : mcnt + 1;
         exp_r1 = a;
         exp_pulse = tb_t;
      end else begin
         exp_pulse = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("result_0", {31'd0, result_0}, {31'd0, exp_pulse});
      chk("result_1", result_1, exp_r1);
      chk("result_2", result_2, mb);
      chk("result_3", result_3, mc);
      chk("result_4", result_4, md);
      if (result_0 === 1'b1) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_pop: observed empty queue expected a pending evaluation");
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_b", result_2, e.b);
            chk("sb_c", result_3, e.c);
            chk("sb_d", result_4, e.d);
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic restart();
      rst = 1'b0;
      run(2);
      rst = 1'b1;
   endtask

   initial begin
      int n;
      rst = 1'b0; en = 1'b1; a = 32'sd7;
      model_reset();

      // Held in reset: everything stays zero despite en=1 and a=7.
      run(5);
      chk("rst_r0", {31'd0, result_0}, 32'd0);
      chk("rst_r1", result_1, 32'd0);
      chk("rst_r4", result_4, 32'd0);

      // Constant input a=5.
      rst = 1'b1; a = 32'sd5;
      run(PB);
      chk("const_b_pulse", {31'd0, result_0}, 32'd1);
      chk("const_b1", result_2, 32'd5);
      chk("const_c1", result_3, 32'd0);
      chk("const_d1", result_4, 32'd0);
      run(PB);
      chk("const_c2", result_3, 32'd5);
      run(2 * PB);
      chk("const_b4", result_2, 32'd5);
      chk("const_c4", result_3, 32'd10);
      chk("const_d4", result_4, 32'd15);

      // Stepped input a=k during the k-th b period.
      restart();
      for (int k = 1; k <= 8; k++) begin
         a = k;
         run(PB);
      end
      chk("step_b8", result_2, 32'd8);
      chk("step_c8", result_3, 32'd20);
      chk("step_d8", result_4, 32'd28);

      // Enable gating just before the first b tick delays it by the gap length.
      restart();
      a = 32'sd3;
      run(PB - 10);
      en = 1'b0;
      run(50);
      en = 1'b1;
      n = 0;
      while (result_0 !== 1'b1 && n < 2 * PB) begin
         cycle();
         n++;
      end
      chk("en_delay", n, 32'd10);
      chk("en_b", result_2, 32'd3);

      // Two's-complement wrap with a = 0x7FFFFFFF.
      restart();
      a = 32'sh7FFF_FFFF;
      run(PD);
      chk("wrap_c", result_3, 32'hFFFF_FFFE);
      chk("wrap_d", result_4, 32'h7FFF_FFFD);

      // Asynchronous reset in the middle of a hyperperiod.
      run(2 * PB + PB / 2);
      #3;
      rst = 1'b0;
      #1;
      chk("async_r0", {31'd0, result_0}, 32'd0);
      chk("async_r1", result_1, 32'd0);
      chk("async_r2", result_2, 32'd0);
      chk("async_r3", result_3, 32'd0);
      chk("async_r4", result_4, 32'd0);
      model_reset();
      run(2);
      rst = 1'b1;
      a = -32'sd4;
      n = 0;
      while (result_0 !== 1'b1 && n < 2 * PB) begin
         cycle();
         n++;
      end
      chk("async_restart", n, PB);
      chk("async_b", result_2, 32'hFFFF_FFFC);

      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rtlola_diff_freq_monitor.md
# rtlola_diff_freq_monitor

Hardware runtime monitor for a small RTLola specification with one 32-bit signed input stream and three periodic output streams running at different frequencies (10 kHz, 5 kHz, 2.5 kHz). It is derived from a 100 MHz system clock. It sits between the sensor/event interface and the verdict-collection logic. It exposes the latest input value, the three output-stream values and a one-cycle evaluation strobe.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency that all periods are derived from.
- PERIOD_B, 10000, cycles between evaluations of stream b (10 kHz).
- PERIOD_C, 20000, cycles between evaluations of stream c (5 kHz); must equal 2×PERIOD_B.
- PERIOD_D, 40000, cycles between evaluations of stream d (2.5 kHz); must equal 2×PERIOD_C.
- clk  in  1  system clock; all logic on rising edge. One clock; reset is asynchronous and active-low.
- rst  in  1  asynchronous active-low reset; asserting it (0) clears all state immediately.
- en  in  1  clock enable; when 0 all state holds.
- a  in  32  signed input stream value, sampled every enabled cycle.
- result_0  out  1  eval strobe; 1 for one cycle after any periodic stream evaluates.
- result_1  out  32  signed, registered copy of input a.
- result_2  out  32  signed, stream b.
- result_3  out  32  signed, stream c.
- result_4  out  32  signed, stream d.

## Operation
- Stream definitions:
  - b @10 kHz = a.hold(), the latest a.
  - c @5 kHz = c.offset(-1).defaults(0) + b.
  - d @2.5 kHz = c + b.
- Single hyperperiod counter `cnt`, range 0..PERIOD_D−1. It increments on every enabled cycle and wraps from PERIOD_D−1 to 0.
- Tick conditions, evaluated in the enabled cycle where the condition holds:
  - tick_b: (cnt+1) mod PERIOD_B == 0.
  - tick_c: (cnt+1) mod PERIOD_C == 0.
  - tick_d: cnt == PERIOD_D−1.
- Every enabled cycle: result_1 <= a.
- On tick_b: b <= a, using the port value in that same cycle.
- On tick_c: c <= c + a.
  - This uses the new b value, because synchronous access happens within the same timestamp.
- On tick_d: d <= (c + a) + a, i.e. new c plus new b.
- Evaluation order within a timestamp is b, then c, then d. All three are computed combinationally from current state and a, then registered together.
- result_0 <= tick_b (tick_c and tick_d always coincide with tick_b). It is 0 in all other cycles.
- Arithmetic is 32-bit two's complement; overflow wraps silently with no saturation or flag.
- en=0: cnt, all outputs and all stream registers hold; result_0 is forced to 0.

## Timing
- Reset values: cnt=0, result_0=0, result_1..result_4=0, stream c history=0.
- Reset asserted mid-operation clears everything asynchronously. After release, counting restarts from cnt=0.
- Latency: all outputs are registered, one cycle after the sampling edge.
- First b evaluation: the PERIOD_B-th enabled cycle after reset release (cycle 10000). Outputs update at the following edge.
- First c evaluation: cycle 20000. First d evaluation: cycle 40000. The pattern then repeats every 40000 enabled cycles.
- At a d tick, b, c, d and result_0 all update on the same edge.
- Cycles with en=0 are not counted, so they stretch the real-time periods.

## Test plan
- Reset check: hold rst=0 with en=1 and a=7 → all results stay 0 and result_0 stays 0.
- Constant input: release reset, a=5 constant.
  - After cycle 10000: result_2=5, result_3=0, result_4=0, result_0 pulses once.
  - After cycle 20000: result_3=5.
  - After cycle 40000: result_2=5, result_3=10, result_4=15.
- Stepped input: apply a=1,2,3,… changing every 10000 cycles, aligned to the b ticks.
  - result_2 follows a; result_3 accumulates 2, 2+4, …; result_4 equals new c plus new b at each d tick.
- Enable gating: deassert en for 500 cycles around cycle 9990 → b tick is delayed by exactly 500 cycles and result_0 stays low while en=0.
- Wrap-around: a=32'h7FFFFFFF constant → at cycle 40000, c=32'hFFFFFFFE and d=32'h7FFFFFFD (two's-complement wrap).
- Async reset mid-run: assert rst at cycle 25000 → outputs clear without waiting for a clock edge. After release, the next b tick arrives 10000 cycles later.
